// File: rtl/display_scan_ctrl.sv
// 4-digit 7-seg scan scheduler: four debug pages, frame-coherent snapshots, debounced page button.
// Optional auto page advance when DISPLAY_AUTO_PAGE_EN is defined.
module display_scan_ctrl #(
  parameter int SCAN_DIV    = 40000,
  parameter int DEB_CYCLES  = 20000,
  parameter int AUTO_FRAMES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        page_btn,
  input  logic        sel_mode,
  input  logic [1:0]  page_sel_in,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  output logic [6:0]  seg,
  output logic [3:0]  select,
  output logic [1:0]  page
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_REL} btn_state_t;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          pending;
  logic [1:0]    sync;
  btn_state_t    btn_state;
  logic [DW-1:0] deb_cnt;

  logic          tick;
  logic          frame;
  logic          press;
  logic          auto_hit;
  logic [1:0]    idx_next;
  logic [1:0]    page_next;
  logic [15:0]   page_data;
  logic [15:0]   frame_data;
  logic [3:0]    nib;
  logic [3:0]    sel_pat;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef DISPLAY_AUTO_PAGE_EN
  localparam int FW = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;
  logic [FW-1:0] frame_cnt;

  assign auto_hit = sel_mode && (frame_cnt == FW'(AUTO_FRAMES - 1));

  // Counts frame boundaries spent in button mode; any press or direct mode restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (press || !sel_mode) begin
      frame_cnt <= '0;
    end else if (frame) begin
      frame_cnt <= auto_hit ? '0 : frame_cnt + FW'(1);
    end
  end
`else
  assign auto_hit = 1'b0;
`endif

  always_comb begin
    tick     = (cnt == CW'(SCAN_DIV - 1));
    idx_next = idx + 2'd1;
    frame    = tick && (idx == 2'd3);

    page_next = page;
    if (!sel_mode)
      page_next = page_sel_in;
    else if (pending || auto_hit)
      page_next = page + 2'd1;

    case (page_next)
      2'd0:    page_data = data0;
      2'd1:    page_data = data1;
      2'd2:    page_data = data2;
      default: page_data = data3;
    endcase

    // On a frame boundary the first digit must come from the snapshot being taken now.
    frame_data = frame ? page_data : snap;

    case (idx_next)
      2'd0:    begin nib = frame_data[15:12]; sel_pat = 4'b0111; end
      2'd1:    begin nib = frame_data[11:8];  sel_pat = 4'b1011; end
      2'd2:    begin nib = frame_data[7:4];   sel_pat = 4'b1101; end
      default: begin nib = frame_data[3:0];   sel_pat = 4'b1110; end
    endcase

    press = (btn_state == DEBOUNCE) && sync[1] && (deb_cnt == DW'(DEB_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= 2'd3;
      snap    <= '0;
      page    <= 2'd0;
      pending <= 1'b0;
      seg     <= 7'h7F;
      select  <= 4'b1111;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx    <= idx_next;
        seg    <= hex7(nib);
        select <= sel_pat;
      end
      if (frame) begin
        page    <= page_next;
        snap    <= page_data;
        pending <= 1'b0;
      end
      // A press landing on a boundary survives the clear and applies next frame.
      if (press && sel_mode)
        pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b00;
      btn_state <= IDLE;
      deb_cnt   <= '0;
    end else begin
      sync <= {sync[0], page_btn};
      case (btn_state)
        IDLE: begin
          if (sync[1]) begin
            btn_state <= DEBOUNCE;
            deb_cnt   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!sync[1])
            btn_state <= IDLE;
          else if (deb_cnt == DW'(DEB_CYCLES - 1))
            btn_state <= WAIT_REL;
          else
            deb_cnt <= deb_cnt + DW'(1);
        end
        WAIT_REL: begin
          if (!sync[1])
            btn_state <= IDLE;
        end
        default: btn_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: slot-count model of the scan plus directed literal checks.
module tb_display_scan_ctrl;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int AF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        page_btn = 1'b0;
  logic        sel_mode = 1'b0;
  logic [1:0]  page_sel_in = 2'd0;
  logic [15:0] data0 = 16'h1A2F;
  logic [15:0] data1 = 16'h1234;
  logic [15:0] data2 = 16'hC0DE;
  logic [15:0] data3 = 16'h89B5;
  logic [6:0]  seg;
  logic [3:0]  select;
  logic [1:0]  page;

  display_scan_ctrl #(.SCAN_DIV(SD), .DEB_CYCLES(DB), .AUTO_FRAMES(AF)) dut (
    .clk(clk), .rst_n(rst_n), .page_btn(page_btn), .sel_mode(sel_mode),
    .page_sel_in(page_sel_in), .data0(data0), .data1(data1), .data2(data2),
    .data3(data3), .seg(seg), .select(select), .page(page)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  logic [6:0] hexlut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] e1 [4] = '{7'h79, 7'h08, 7'h24, 7'h0E};

  // Model: clocks since last slot, slots since reset, button high run length.
  int          m_phase, m_ticks, m_run, m_fc;
  logic [1:0]  m_page;
  logic        m_pend;
  logic [15:0] m_snap;
  logic [6:0]  m_seg;
  logic [3:0]  m_sel;
  logic        m_s1, m_s2;

  function automatic logic [15:0] pdata(input logic [1:0] p);
    case (p)
      2'd0:    return data0;
      2'd1:    return data1;
      2'd2:    return data2;
      default: return data3;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_run = 0; m_fc = 0;
    m_page = 2'd0; m_pend = 1'b0; m_snap = 16'h0;
    m_seg = 7'h7F; m_sel = 4'b1111; m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic model_step();
    logic lvl, press, frame, hit;
    int   digit;
    lvl   = m_s2;
    m_s2  = m_s1;
    m_s1  = page_btn;
    m_run = lvl ? m_run + 1 : 0;
    press = (m_run == DB + 1);
    hit   = 1'b0;
    if (m_phase == SD - 1) begin
      m_phase = 0;
      digit   = m_ticks % 4;
      frame   = (digit == 0);
      m_ticks = m_ticks + 1;
      if (frame) begin
`ifdef DISPLAY_AUTO_PAGE_EN
        if (sel_mode) begin
          hit  = (m_fc + 1 == AF);
          m_fc = hit ? 0 : m_fc + 1;
        end
`endif
        if (!sel_mode) m_page = page_sel_in;
        else if (m_pend || hit) m_page = m_page + 2'd1;
        m_pend = 1'b0;
        m_snap = pdata(m_page);
      end
      m_seg = hexlut[(m_snap >> (12 - 4 * digit)) & 16'hF];
      m_sel = ~(4'b1000 >> digit);
    end else begin
      m_phase = m_phase + 1;
    end
    if (!sel_mode || press) m_fc = 0;
    if (press && sel_mode) m_pend = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model seg", {9'd0, seg}, {9'd0, m_seg});
      check("model select", {12'd0, select}, {12'd0, m_sel});
      check("model page", {14'd0, page}, {14'd0, m_page});
    end
  end

  task automatic to_neg(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_btn();
    page_btn = 1'b1;
    to_neg(4);
    page_btn = 1'b0;
    to_neg(2);
  endtask

  task automatic sync_frame();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_phase == 0 && m_ticks % 4 == 1) found = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL sync_frame: frame boundary not seen within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset seg", {9'd0, seg}, 16'h007F);
    check("reset select", {12'd0, select}, 16'h000F);
    check("reset page", {14'd0, page}, 16'h0000);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Static page 0, then a mid-frame data change must not tear the frame.
    for (int f = 0; f < 4; f++) begin
      for (int d = 0; d < 4; d++) begin
        to_neg(4);
        check("slot seg", {9'd0, seg}, {9'd0, (f == 3) ? 7'h0E : e1[d]});
        check("slot select", {12'd0, select}, {12'd0, ~(4'b1000 >> d)});
        if (f == 2 && d == 0) data0 = 16'hFFFF;
      end
    end
    data0 = 16'h1A2F;

`ifndef DISPLAY_AUTO_PAGE_EN
    sel_mode = 1'b1;
    page_btn = 1'b1;
    to_neg(10);
    page_btn = 1'b0;
    to_neg(9);
    check("held press before boundary", {14'd0, page}, 16'd0);
    to_neg(1);
    check("held press one advance", {14'd0, page}, 16'd1);
    check("page1 first digit", {9'd0, seg}, 16'h0079);

    page_btn = 1'b1;
    to_neg(2);
    page_btn = 1'b0;
    to_neg(40);
    check("glitch ignored", {14'd0, page}, 16'd1);

    sync_frame();
    press_btn();
    press_btn();
    to_neg(4);
    check("double press single advance", {14'd0, page}, 16'd2);
    press_btn();
    to_neg(10);
    check("press to page3", {14'd0, page}, 16'd3);
    press_btn();
    to_neg(10);
    check("press wraps to 0", {14'd0, page}, 16'd0);

    sel_mode    = 1'b0;
    page_sel_in = 2'd2;
    press_btn();
    to_neg(10);
    check("direct select page2", {14'd0, page}, 16'd2);
    sel_mode = 1'b1;
    to_neg(16);
    check("direct-mode press discarded", {14'd0, page}, 16'd2);

    to_neg(6);
    #2 rst_n = 1'b0;
    #1;
    check("async reset seg", {9'd0, seg}, 16'h007F);
    check("async reset select", {12'd0, select}, 16'h000F);
    check("async reset page", {14'd0, page}, 16'd0);
    to_neg(2);
    rst_n = 1'b1;
    to_neg(4);
    check("restart seg", {9'd0, seg}, 16'h0079);
    check("restart select", {12'd0, select}, 16'h0007);
    to_neg(4);
    check("restart seg 2nd", {9'd0, seg}, 16'h0008);
    to_neg(24);
`else
    sel_mode = 1'b1;
    to_neg(4);
    check("auto first boundary", {14'd0, page}, 16'd0);
    to_neg(16);
    check("auto advance 1", {14'd0, page}, 16'd1);
    to_neg(16);
    check("auto hold", {14'd0, page}, 16'd1);
    to_neg(16);
    check("auto advance 2", {14'd0, page}, 16'd2);
    sel_mode    = 1'b0;
    page_sel_in = 2'd3;
    to_neg(16);
    check("direct overrides auto", {14'd0, page}, 16'd3);
    to_neg(32);
    check("direct holds", {14'd0, page}, 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
